// File: rtl/fetch_pkg.sv
// Shared types for the instruction-fetch front end.
package fetch_pkg;

  localparam int unsigned FETCH_XLEN = 32;
  localparam int unsigned PC_STEP    = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } fetch_state_t;

  typedef struct packed {
    logic [FETCH_XLEN-1:0] instr;
    logic [FETCH_XLEN-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush; holds prefetched entries and the PC tag queue.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter type         T     = fetch_entry_t,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  T              din,
  output T              dout,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  T               mem [DEPTH];
  logic [AW-1:0]  rd_ptr;
  logic [AW-1:0]  wr_ptr;
  logic           do_push;
  logic           do_pop;

  function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
    return (32'(p) == DEPTH - 1) ? '0 : p + 1'b1;
  endfunction

  assign full    = (32'(count) == DEPTH);
  assign empty   = (count == '0);
  assign do_pop  = pop && !flush && !empty;
  assign do_push = push && !flush && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; flush empties the queue in one cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= bump(wr_ptr);
      if (do_pop)  rd_ptr <= bump(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Storage array; contents are only observed through a non-empty head.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: PC, memory read requests, prefetch FIFO.
// Optional FETCH_PERF_EN adds saturating fetched/discarded counters.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned          DATA_WIDTH      = 32,
  parameter int unsigned          FIFO_DEPTH      = 4,
  parameter int unsigned          MAX_OUTSTANDING = 2,
  parameter logic [DATA_WIDTH-1:0] RESET_PC       = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  req_valid,
  input  logic                  req_ready,
  output logic [DATA_WIDTH-1:0] req_addr,
  input  logic                  rsp_valid,
  input  logic [DATA_WIDTH-1:0] rsp_data,
  input  logic                  redirect,
  input  logic [DATA_WIDTH-1:0] redirect_pc,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [DATA_WIDTH-1:0] instr_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]           perf_fetched,
  output logic [31:0]           perf_discarded
`endif
);

  localparam int unsigned FCW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned OCW = $clog2(MAX_OUTSTANDING + 1);

  fetch_state_t          state, state_nxt;
  logic [DATA_WIDTH-1:0] pc, pc_nxt;
  logic [OCW-1:0]        discard, discard_nxt;
  logic [OCW-1:0]        outstanding;
  logic [FCW-1:0]        fifo_count;
  logic                  fifo_full, fifo_empty;
  logic                  tag_full, tag_empty;
  logic [DATA_WIDTH-1:0] tag_head;
  fetch_entry_t          ifq_din, ifq_head;
  logic                  redir, req_fire, push, pop;

  // Redirect in IDLE is ignored; requests are not gated by a same-cycle
  // redirect, so an accepted request is counted into discard instead.
  assign redir     = redirect && (state != IDLE);
  assign req_valid = (state == RUN) && !tag_full && !fifo_full &&
                     (32'(fifo_count) + 32'(outstanding) < FIFO_DEPTH);
  assign req_addr  = pc;
  assign req_fire  = req_valid && req_ready;
  assign push      = rsp_valid && !tag_empty && !redir && (discard == '0);
  assign pop       = instr_valid && instr_ready && !redir;
  assign ifq_din   = '{instr: rsp_data, pc: tag_head};

  assign instr_valid = !fifo_empty;
  assign instr       = instr_valid ? ifq_head.instr : '0;
  assign instr_pc    = instr_valid ? ifq_head.pc : '0;

  fetch_fifo #(.T(fetch_entry_t), .DEPTH(FIFO_DEPTH)) u_ifq (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (redir),
    .din   (ifq_din),
    .dout  (ifq_head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Tag queue: one PC per accepted request, retired by every response.
  fetch_fifo #(.T(logic [DATA_WIDTH-1:0]), .DEPTH(MAX_OUTSTANDING)) u_tagq (
    .clk   (clk),
    .rst   (rst),
    .push  (req_fire),
    .pop   (rsp_valid),
    .flush (1'b0),
    .din   (pc),
    .dout  (tag_head),
    .count (outstanding),
    .full  (tag_full),
    .empty (tag_empty)
  );

  // State, PC and discard-count registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      pc      <= RESET_PC;
      discard <= '0;
    end else begin
      state   <= state_nxt;
      pc      <= pc_nxt;
      discard <= discard_nxt;
    end
  end

  // Next-state, PC advance and stale-response accounting.
  always_comb begin
    state_nxt   = state;
    pc_nxt      = pc;
    discard_nxt = discard;
    case (state)
      IDLE:    state_nxt = RUN;
      RUN:     ;
      DRAIN:   ;
      default: state_nxt = IDLE;
    endcase
    if (req_fire) pc_nxt = pc + DATA_WIDTH'(PC_STEP);
    if (rsp_valid && discard != '0) discard_nxt = discard - 1'b1;
    if (state == DRAIN && discard_nxt == '0) state_nxt = RUN;
    if (redir) begin
      pc_nxt      = redirect_pc & ~DATA_WIDTH'(3);
      discard_nxt = outstanding + OCW'(req_fire) - OCW'(rsp_valid);
      state_nxt   = (discard_nxt != '0) ? DRAIN : RUN;
    end
  end

`ifdef FETCH_PERF_EN
  logic [32:0] disc_sum;

  // Dropped responses plus entries thrown away by a flush.
  always_comb begin
    disc_sum = {1'b0, perf_discarded}
             + 33'(rsp_valid && (redir || discard != '0))
             + (redir ? 33'(fifo_count) : 33'd0);
  end

  // Saturating performance counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_fetched   <= '0;
      perf_discarded <= '0;
    end else begin
      if (push && perf_fetched != '1) perf_fetched <= perf_fetched + 1'b1;
      perf_discarded <= disc_sum[32] ? '1 : disc_sum[31:0];
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed table, corner sequences,
// and randomized traffic against a stream-level reference model.
module tb_fetch_unit;

  localparam int unsigned MAX_OUT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid, req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        instr_valid, instr_ready;
  logic [31:0] instr, instr_pc;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_discarded;
`endif

  fetch_unit #(
    .DATA_WIDTH      (32),
    .FIFO_DEPTH      (4),
    .MAX_OUTSTANDING (MAX_OUT),
    .RESET_PC        (32'h0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .instr_pc    (instr_pc)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_discarded (perf_discarded)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state: expected address streams and FIFO occupancy.
  typedef struct { logic [31:0] addr; int due; } pend_t;
  pend_t       pend[$];
  logic [31:0] exp_req, exp_pc;
  int          stale, occ, cyc, lat;
  int          m_fetched, m_disc;
  logic        prv_rv, prv_acc, prv_redir, prv_iv, prv_irdy;
  logic [31:0] prv_addr, prv_instr, prv_ipc;

  typedef struct {
    logic        irdy;
    logic        rv;
    logic [31:0] addr;
    logic        iv;
    logic [31:0] ipc;
  } vec_t;
  vec_t tbl[17];

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_clear();
    pend.delete();
    exp_req = 32'h0; exp_pc = 32'h0;
    stale = 0; occ = 0; cyc = 0;
    m_fetched = 0; m_disc = 0;
    prv_rv = 0; prv_acc = 0; prv_redir = 0; prv_iv = 0; prv_irdy = 0;
    prv_addr = '0; prv_instr = '0; prv_ipc = '0;
  endtask

  task automatic idle_inputs();
    req_ready = 0; rsp_valid = 0; rsp_data = '0;
    redirect = 0; redirect_pc = '0; instr_ready = 0;
  endtask

  task automatic check_reset_outputs();
    check("rst_req_valid", 32'(req_valid), 32'h0);
    check("rst_req_addr", req_addr, 32'h0);
    check("rst_instr_valid", 32'(instr_valid), 32'h0);
    check("rst_instr", instr, 32'h0);
    check("rst_instr_pc", instr_pc, 32'h0);
`ifdef FETCH_PERF_EN
    check("rst_perf_fetched", perf_fetched, 32'h0);
    check("rst_perf_discarded", perf_discarded, 32'h0);
`endif
  endtask

  // Called at a falling edge: check, run memory + model, drive, advance.
  task automatic cycle(input logic rreq, input logic rinstr, input logic redir, input logic [31:0] rpc);
    logic        acc;
    logic [31:0] a;
    if (req_valid) check("req_addr", req_addr, exp_req);
    if (stale > 0) check("drain_no_req", 32'(req_valid), 32'h0);
    if (prv_rv && !prv_acc && !prv_redir) begin
      check("req_hold_valid", 32'(req_valid), 32'h1);
      check("req_hold_addr", req_addr, prv_addr);
    end
    check("instr_valid_occ", 32'(instr_valid), 32'(occ > 0));
    if (prv_iv && !prv_irdy && !prv_redir) begin
      check("instr_hold", instr, prv_instr);
      check("instr_pc_hold", instr_pc, prv_ipc);
    end
    rsp_valid = 0; rsp_data = '0;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      a = pend.pop_front().addr;
      rsp_valid = 1; rsp_data = memf(a);
      if (redir || stale > 0) begin
        m_disc++;
        if (stale > 0) stale--;
      end else begin
        occ++; m_fetched++;
      end
    end
    acc = req_valid && rreq;
    if (acc) begin
      pend.push_back('{req_addr, cyc + lat});
      exp_req += 32'd4;
      check("outstanding_limit", 32'(pend.size() <= MAX_OUT), 32'h1);
    end
    if (redir) begin
      exp_req = rpc & 32'hFFFF_FFFC;
      exp_pc  = exp_req;
      stale   = pend.size();
      m_disc += occ;
      occ     = 0;
    end else if (instr_valid && rinstr) begin
      check("instr_pc", instr_pc, exp_pc);
      check("instr_data", instr, memf(exp_pc));
      exp_pc += 32'd4;
      if (occ > 0) occ--;
    end
    req_ready = rreq; instr_ready = rinstr; redirect = redir; redirect_pc = rpc;
    prv_rv = req_valid; prv_acc = acc; prv_redir = redir; prv_addr = req_addr;
    prv_iv = instr_valid; prv_irdy = rinstr; prv_instr = instr; prv_ipc = instr_pc;
    @(negedge clk);
    cyc++;
  endtask

  task automatic reset_release();
    rst = 0;
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    rst = 1;
    model_clear();
  endtask

  task automatic run_table();
    for (int unsigned i = 0; i < 17; i++) begin
      check("tbl_req_valid", 32'(req_valid), 32'(tbl[i].rv));
      if (tbl[i].rv) check("tbl_req_addr", req_addr, tbl[i].addr);
      check("tbl_instr_valid", 32'(instr_valid), 32'(tbl[i].iv));
      if (tbl[i].iv) check("tbl_instr_pc", instr_pc, tbl[i].ipc);
      cycle(1'b1, tbl[i].irdy, 1'b0, 32'h0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    // latency 1, decode ready, then a 4-cycle decode stall and release
    tbl[0]  = '{1'b1, 1'b0, 32'h00, 1'b0, 32'h00};
    tbl[1]  = '{1'b1, 1'b1, 32'h00, 1'b0, 32'h00};
    tbl[2]  = '{1'b1, 1'b1, 32'h04, 1'b0, 32'h00};
    tbl[3]  = '{1'b1, 1'b1, 32'h08, 1'b1, 32'h00};
    tbl[4]  = '{1'b1, 1'b1, 32'h0C, 1'b1, 32'h04};
    tbl[5]  = '{1'b1, 1'b1, 32'h10, 1'b1, 32'h08};
    tbl[6]  = '{1'b1, 1'b1, 32'h14, 1'b1, 32'h0C};
    tbl[7]  = '{1'b1, 1'b1, 32'h18, 1'b1, 32'h10};
    tbl[8]  = '{1'b0, 1'b1, 32'h1C, 1'b1, 32'h14};
    tbl[9]  = '{1'b0, 1'b1, 32'h20, 1'b1, 32'h14};
    tbl[10] = '{1'b0, 1'b0, 32'h00, 1'b1, 32'h14};
    tbl[11] = '{1'b0, 1'b0, 32'h00, 1'b1, 32'h14};
    tbl[12] = '{1'b1, 1'b0, 32'h00, 1'b1, 32'h14};
    tbl[13] = '{1'b1, 1'b1, 32'h24, 1'b1, 32'h18};
    tbl[14] = '{1'b1, 1'b1, 32'h28, 1'b1, 32'h1C};
    tbl[15] = '{1'b1, 1'b1, 32'h2C, 1'b1, 32'h20};
    tbl[16] = '{1'b1, 1'b1, 32'h30, 1'b1, 32'h24};

    idle_inputs();
    model_clear();
    lat = 1;
    #3;
    check_reset_outputs();
    reset_release();
    run_table();

    // Two stale requests in flight at latency 3, redirect to 0x103
    reset_release();
    lat = 3;
    cycle(1'b0, 1'b1, 1'b0, 32'h0);            // c0 IDLE
    cycle(1'b0, 1'b1, 1'b1, 32'h10);           // c1 redirect to 0x10
    cycle(1'b1, 1'b1, 1'b0, 32'h0);            // c2 accept 0x10
    cycle(1'b1, 1'b1, 1'b0, 32'h0);            // c3 accept 0x14
    check("a_full_no_req", 32'(req_valid), 32'h0);
    cycle(1'b1, 1'b1, 1'b1, 32'h103);          // c4 redirect
    check("a_drain1_no_req", 32'(req_valid), 32'h0);
    cycle(1'b1, 1'b1, 1'b0, 32'h0);            // c5 stale 0x10 dropped
    check("a_drain2_no_req", 32'(req_valid), 32'h0);
    cycle(1'b1, 1'b1, 1'b0, 32'h0);            // c6 stale 0x14 dropped
    check("a_resume_valid", 32'(req_valid), 32'h1);
    check("a_resume_addr", req_addr, 32'h100);
    for (int k = 7; k < 11; k++) cycle(1'b1, 1'b1, 1'b0, 32'h0);
    check("a_first_valid", 32'(instr_valid), 32'h1);
    check("a_first_pc", instr_pc, 32'h100);
    for (int k = 0; k < 8; k++) cycle(1'b1, 1'b1, 1'b0, 32'h0);

    // Redirect coinciding with request acceptance and a response
    reset_release();
    lat = 1;
    cycle(1'b1, 1'b1, 1'b0, 32'h0);            // c0 IDLE
    cycle(1'b1, 1'b1, 1'b0, 32'h0);            // c1 accept 0x0
    cycle(1'b1, 1'b1, 1'b1, 32'h200);          // c2 rsp 0x0, accept 0x4, redirect
    check("b_drain_no_req", 32'(req_valid), 32'h0);
    check("b_no_stale_c3", 32'(instr_valid), 32'h0);
    cycle(1'b1, 1'b1, 1'b0, 32'h0);            // c3 stale 0x4 dropped
    check("b_resume_addr", req_addr, 32'h200);
    check("b_no_stale_c4", 32'(instr_valid), 32'h0);
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    check("b_no_stale_c5", 32'(instr_valid), 32'h0);
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    check("b_first_valid", 32'(instr_valid), 32'h1);
    check("b_first_pc", instr_pc, 32'h200);
    for (int k = 0; k < 6; k++) cycle(1'b1, 1'b1, 1'b0, 32'h0);

    // PC wrap at the top of the address space
    reset_release();
    cycle(1'b0, 1'b1, 1'b0, 32'h0);
    cycle(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFE);
    check("c_top_addr", req_addr, 32'hFFFF_FFFC);
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    check("c_wrap_valid", 32'(req_valid), 32'h1);
    check("c_wrap_addr", req_addr, 32'h0);
    for (int k = 0; k < 8; k++) cycle(1'b1, 1'b1, 1'b0, 32'h0);

    // Randomized traffic
    reset_release();
    for (int k = 0; k < 3000; k++) begin
      logic        rr, ir, rd;
      logic [31:0] rp;
      if (k % 200 == 0) lat = $urandom_range(1, 3);
      rr = ($urandom_range(0, 3) != 0);
      ir = ($urandom_range(0, 3) != 0);
      rd = (cyc >= 2) && ($urandom_range(0, 19) == 0);
      rp = ($urandom_range(0, 9) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      cycle(rr, ir, rd, rp);
    end
`ifdef FETCH_PERF_EN
    check("perf_fetched", perf_fetched, 32'(m_fetched));
    check("perf_discarded", perf_discarded, 32'(m_disc));
`endif

    // Asynchronous reset in the middle of traffic, then restart cleanly
    #3;
    rst = 0;
    #1;
    check_reset_outputs();
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    rst = 1;
    model_clear();
    lat = 1;
    run_table();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
